// File: rtl/l2_req_arbiter_pkg.sv
// l2_arb_pkg: FSM state type and line-width helper shared by the l2_req_arbiter slice
package l2_arb_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_t;
  function automatic int line_w(input int offset_w);
    return 32 << offset_w;
  endfunction
endpackage

// File: rtl/l2_req_arbiter_if.sv
// l2_req_arbiter_if: L1 client bus plus L2 request port; master = arbiter, slave = clients and L2
interface l2_req_arbiter_if #(
  parameter int N_CH = 2,
  parameter int L1_OFFSET_W = 2
);
  import l2_arb_pkg::*;
  localparam int LINE_W = line_w(L1_OFFSET_W);
  logic [N_CH-1:0]    req_l1_arb;
  logic [32*N_CH-1:0] addr_l1_arb;
  logic [32*N_CH-1:0] din_l1_arb;
  logic [N_CH-1:0]    wr_l1_arb;
  logic [4*N_CH-1:0]  wstrb_l1_arb;
  logic [N_CH-1:0]    addrOK_arb_l1;
  logic [N_CH-1:0]    dataOK_arb_l1;
  logic [LINE_W-1:0]  dout_arb_l1;
  logic               req_arb_l2;
  logic [31:0]        addr_arb_l2;
  logic [31:0]        din_arb_l2;
  logic               wr_arb_l2;
  logic [3:0]         wstrb_arb_l2;
  logic               addrOK_l2_arb;
  logic               dataOK_l2_arb;
  logic [LINE_W-1:0]  dout_l2_arb;
  modport master (
    input  req_l1_arb, addr_l1_arb, din_l1_arb, wr_l1_arb, wstrb_l1_arb,
    input  addrOK_l2_arb, dataOK_l2_arb, dout_l2_arb,
    output addrOK_arb_l1, dataOK_arb_l1, dout_arb_l1,
    output req_arb_l2, addr_arb_l2, din_arb_l2, wr_arb_l2, wstrb_arb_l2
  );
  modport slave (
    output req_l1_arb, addr_l1_arb, din_l1_arb, wr_l1_arb, wstrb_l1_arb,
    output addrOK_l2_arb, dataOK_l2_arb, dout_l2_arb,
    input  addrOK_arb_l1, dataOK_arb_l1, dout_arb_l1,
    input  req_arb_l2, addr_arb_l2, din_arb_l2, wr_arb_l2, wstrb_arb_l2
  );
endinterface

// File: rtl/l2_req_arbiter_rr_pick.sv
// rr_pick: rotate-and-priority-encode picker; with L2_ARB_FIXED_PRIO_EN it is a plain lowest-index encoder
module rr_pick #(
  parameter int N_CH = 2,
  parameter int IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  win_oh,
  output logic [IDX_W-1:0] win_idx
);
  logic [IDX_W-1:0]  base;
  logic [2*N_CH-1:0] dbl;
  logic              found;
`ifdef L2_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  assign base = ptr;
`endif
  assign dbl = {req, req} >> base;
  always_comb begin
    found = 1'b0;
    win_idx = '0;
    for (int k = 0; k < N_CH; k++)
      if (!found && dbl[k]) begin
        found = 1'b1;
        win_idx = IDX_W'((int'(base) + k) % N_CH);
      end
  end
  assign win_oh = found ? (N_CH'(1) << win_idx) : '0;
endmodule

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: N-channel L1->L2 request arbiter, round-robin or fixed priority (L2_ARB_FIXED_PRIO_EN)
module l2_req_arbiter import l2_arb_pkg::*; #(
  parameter int N_CH = 2,
  parameter int L1_OFFSET_W = 2,
  parameter int IDX_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rstn,
  l2_req_arbiter_if.master bus,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx
);
  localparam int LINE_W = line_w(L1_OFFSET_W);
  arb_state_t       state;
  logic [N_CH-1:0]  grant_oh;
  logic [N_CH-1:0]  win_oh;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] rr_ptr;
  logic [31:0]      addr_q;
  logic [31:0]      din_q;
  logic [3:0]       wstrb_q;
  logic             wr_q;
  logic             req_q;
  logic             done;
  rr_pick #(.N_CH(N_CH), .IDX_W(IDX_W)) u_pick (
    .req(bus.req_l1_arb),
    .ptr(rr_ptr),
    .win_oh(win_oh),
    .win_idx(win_idx)
  );
  // completion counts in DATA, or in ADDR when L2 accepts and finishes in the same cycle
  assign done = bus.dataOK_l2_arb && (state == DATA || (state == ADDR && bus.addrOK_l2_arb));
  assign bus.addrOK_arb_l1 = (state == ADDR && bus.addrOK_l2_arb) ? grant_oh : '0;
  assign bus.dataOK_arb_l1 = done ? grant_oh : '0;
  assign bus.dout_arb_l1 = bus.dout_l2_arb[LINE_W-1:0];
  assign bus.req_arb_l2 = req_q;
  assign bus.addr_arb_l2 = addr_q;
  assign bus.din_arb_l2 = din_q;
  assign bus.wr_arb_l2 = wr_q;
  assign bus.wstrb_arb_l2 = wstrb_q;
`ifdef L2_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) rr_ptr <= '0;
    else if (done) rr_ptr <= (grant_idx == IDX_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
`endif
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      grant_idx <= '0;
      grant_oh <= '0;
      addr_q <= '0;
      din_q <= '0;
      wr_q <= 1'b0;
      wstrb_q <= '0;
      req_q <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|bus.req_l1_arb) begin
          state <= ADDR;
          req_q <= 1'b1;
          busy <= 1'b1;
          grant_idx <= win_idx;
          grant_oh <= win_oh;
          addr_q <= bus.addr_l1_arb[32*win_idx +: 32];
          din_q <= bus.din_l1_arb[32*win_idx +: 32];
          wr_q <= bus.wr_l1_arb[win_idx];
          wstrb_q <= bus.wstrb_l1_arb[4*win_idx +: 4];
        end
        ADDR: if (done) begin
          state <= IDLE;
          req_q <= 1'b0;
          busy <= 1'b0;
        end else if (bus.addrOK_l2_arb) begin
          state <= DATA;
          req_q <= 1'b0;
        end
        DATA: if (done) begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb_l2_req_arbiter: self-checking bench for l2_req_arbiter (3 clients, randomized traffic vs grant model)
module tb_l2_req_arbiter;
  import l2_arb_pkg::*;
  localparam int N = 3;
  localparam int IW = $clog2(N);
  localparam int LW = line_w(2);
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic busy;
  logic [IW-1:0] grant_idx;
  int errs = 0;
  int checks = 0;
  int m_ptr = 0;
  logic [N-1:0] c_req;
  logic [31:0] c_addr [N];
  logic [31:0] c_din [N];
  logic c_wr [N];
  logic [3:0] c_wstrb [N];
  l2_req_arbiter_if #(.N_CH(N), .L1_OFFSET_W(2)) bus();
  l2_req_arbiter #(.N_CH(N), .L1_OFFSET_W(2)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus),
    .busy(busy),
    .grant_idx(grant_idx)
  );
  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] r);
`ifdef L2_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (r[k]) return k;
`else
    for (int k = 0; k < N; k++) if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
    return -1;
  endfunction

  function automatic void served(input int w);
`ifndef L2_ARB_FIXED_PRIO_EN
    m_ptr = (w + 1) % N;
`endif
  endfunction

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      bus.addr_l1_arb[32*c +: 32] = c_addr[c];
      bus.din_l1_arb[32*c +: 32] = c_din[c];
      bus.wr_l1_arb[c] = c_wr[c];
      bus.wstrb_l1_arb[4*c +: 4] = c_wstrb[c];
    end
    bus.req_l1_arb = c_req;
  endtask

  task automatic clear_clients();
    c_req = '0;
    for (int c = 0; c < N; c++) begin
      c_addr[c] = '0;
      c_din[c] = '0;
      c_wr[c] = 1'b0;
      c_wstrb[c] = '0;
    end
  endtask

  task automatic do_reset(input logic [N-1:0] hold);
    @(negedge clk);
    rstn = 1'b0;
    clear_clients();
    c_req = hold;
    drive();
    bus.addrOK_l2_arb = 1'b0;
    bus.dataOK_l2_arb = 1'b0;
    m_ptr = 0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    logic [LW-1:0] line;
    @(negedge clk);
    line = {$urandom, $urandom, $urandom, $urandom};
    bus.dout_l2_arb = line;
    bus.addrOK_l2_arb = 1'b1;
    bus.dataOK_l2_arb = 1'b1;
    c_req = '1;
    drive();
    #1;
    checks++; if (bus.req_arb_l2 !== 1'b0) begin errs++; $display("FAIL rst_req: got %b want 0", bus.req_arb_l2); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (grant_idx !== '0) begin errs++; $display("FAIL rst_gidx: got %0d want 0", grant_idx); end
    checks++; if (bus.addrOK_arb_l1 !== '0 || bus.dataOK_arb_l1 !== '0) begin errs++; $display("FAIL rst_pulses: got %b/%b want 0/0", bus.addrOK_arb_l1, bus.dataOK_arb_l1); end
    checks++; if ({bus.addr_arb_l2, bus.din_arb_l2, bus.wr_arb_l2, bus.wstrb_arb_l2} !== '0) begin errs++; $display("FAIL rst_payload: got %h/%h/%b/%h want 0", bus.addr_arb_l2, bus.din_arb_l2, bus.wr_arb_l2, bus.wstrb_arb_l2); end
    checks++; if (bus.dout_arb_l1 !== line) begin errs++; $display("FAIL rst_dout: got %h want %h", bus.dout_arb_l1, line); end
    do_reset('0);
  endtask

  task automatic test_single_read();
    logic [LW-1:0] line;
    line = {4{32'hA5A5_A5A5}};
    do_reset('0);
    c_req = 3'b010;
    c_addr[1] = 32'h1C00_0040;
    c_wr[1] = 1'b0;
    c_wstrb[1] = 4'hF;
    drive();
    @(negedge clk);
    c_req = '0;
    drive();
    #1;
    checks++; if (bus.req_arb_l2 !== 1'b1 || bus.addr_arb_l2 !== 32'h1C00_0040 || bus.wr_arb_l2 !== 1'b0) begin errs++; $display("FAIL rd_req: got req=%b addr=%h wr=%b want 1/1c000040/0", bus.req_arb_l2, bus.addr_arb_l2, bus.wr_arb_l2); end
    checks++; if (grant_idx !== IW'(1) || busy !== 1'b1) begin errs++; $display("FAIL rd_grant: got idx=%0d busy=%b want 1/1", grant_idx, busy); end
    @(negedge clk);
    @(negedge clk);
    bus.addrOK_l2_arb = 1'b1;
    #1;
    checks++; if (bus.addrOK_arb_l1 !== 3'b010) begin errs++; $display("FAIL rd_addrok: got %b want 010", bus.addrOK_arb_l1); end
    @(negedge clk);
    bus.addrOK_l2_arb = 1'b0;
    #1;
    checks++; if (bus.req_arb_l2 !== 1'b0 || bus.addrOK_arb_l1 !== '0) begin errs++; $display("FAIL rd_reqlow: got req=%b aok=%b want 0/000", bus.req_arb_l2, bus.addrOK_arb_l1); end
    @(negedge clk);
    @(negedge clk);
    bus.dataOK_l2_arb = 1'b1;
    bus.dout_l2_arb = line;
    #1;
    checks++; if (bus.dataOK_arb_l1 !== 3'b010) begin errs++; $display("FAIL rd_dataok: got %b want 010", bus.dataOK_arb_l1); end
    checks++; if (bus.dout_arb_l1 !== line) begin errs++; $display("FAIL rd_dout: got %h want %h", bus.dout_arb_l1, line); end
    @(negedge clk);
    bus.dataOK_l2_arb = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rd_busyfall: got %b want 0", busy); end
  endtask

  task automatic test_same_cycle();
    do_reset('0);
    c_req = 3'b100;
    c_addr[2] = 32'h0000_2000;
    drive();
    @(negedge clk);
    c_req = '0;
    drive();
    bus.addrOK_l2_arb = 1'b1;
    bus.dataOK_l2_arb = 1'b1;
    #1;
    checks++; if (bus.addrOK_arb_l1 !== 3'b100 || bus.dataOK_arb_l1 !== 3'b100) begin errs++; $display("FAIL same_pulses: got %b/%b want 100/100", bus.addrOK_arb_l1, bus.dataOK_arb_l1); end
    @(negedge clk);
    bus.addrOK_l2_arb = 1'b0;
    bus.dataOK_l2_arb = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || bus.req_arb_l2 !== 1'b0) begin errs++; $display("FAIL same_idle: got busy=%b req=%b want 0/0", busy, bus.req_arb_l2); end
  endtask

  task automatic test_capture();
    do_reset('0);
    c_req = 3'b001;
    c_addr[0] = 32'h100;
    c_din[0] = 32'hDEAD_BEEF;
    c_wstrb[0] = 4'h3;
    c_wr[0] = 1'b1;
    drive();
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      c_req = '0;
      c_addr[0] = 32'hFFF0 + j;
      c_din[0] = 32'h0;
      c_wstrb[0] = 4'hF;
      c_wr[0] = 1'b0;
      drive();
      bus.dataOK_l2_arb = (j == 0);
      #1;
      checks++; if (bus.req_arb_l2 !== 1'b1 || bus.addr_arb_l2 !== 32'h100 || bus.din_arb_l2 !== 32'hDEAD_BEEF || bus.wstrb_arb_l2 !== 4'h3 || bus.wr_arb_l2 !== 1'b1) begin errs++; $display("FAIL cap_payload%0d: got %b/%h/%h/%h/%b want 1/100/deadbeef/3/1", j, bus.req_arb_l2, bus.addr_arb_l2, bus.din_arb_l2, bus.wstrb_arb_l2, bus.wr_arb_l2); end
      checks++; if (bus.dataOK_arb_l1 !== '0) begin errs++; $display("FAIL cap_early_dataok%0d: got %b want 000", j, bus.dataOK_arb_l1); end
    end
    @(negedge clk);
    bus.dataOK_l2_arb = 1'b0;
    bus.addrOK_l2_arb = 1'b1;
    #1;
    checks++; if (bus.addrOK_arb_l1 !== 3'b001) begin errs++; $display("FAIL cap_addrok: got %b want 001", bus.addrOK_arb_l1); end
    @(negedge clk);
    bus.addrOK_l2_arb = 1'b0;
    bus.dataOK_l2_arb = 1'b1;
    #1;
    checks++; if (bus.dataOK_arb_l1 !== 3'b001) begin errs++; $display("FAIL cap_dataok: got %b want 001", bus.dataOK_arb_l1); end
    @(negedge clk);
    bus.dataOK_l2_arb = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset('0);
    c_req = 3'b010;
    drive();
    @(negedge clk);
    c_req = '0;
    drive();
    bus.addrOK_l2_arb = 1'b1;
    bus.dataOK_l2_arb = 1'b1;
    @(negedge clk);
    bus.addrOK_l2_arb = 1'b0;
    bus.dataOK_l2_arb = 1'b0;
    c_req = 3'b001;
    drive();
    @(negedge clk);
    c_req = '0;
    drive();
    bus.addrOK_l2_arb = 1'b1;
    @(negedge clk);
    bus.addrOK_l2_arb = 1'b0;
    c_req = 3'b110;
    drive();
    #2;
    rstn = 1'b0;
    bus.dataOK_l2_arb = 1'b1;
    #1;
    checks++; if (bus.req_arb_l2 !== 1'b0 || busy !== 1'b0 || grant_idx !== '0) begin errs++; $display("FAIL mid_async: got req=%b busy=%b idx=%0d want 0/0/0", bus.req_arb_l2, busy, grant_idx); end
    checks++; if (bus.dataOK_arb_l1 !== '0 || bus.addr_arb_l2 !== '0) begin errs++; $display("FAIL mid_clear: got dok=%b addr=%h want 000/0", bus.dataOK_arb_l1, bus.addr_arb_l2); end
    @(negedge clk);
    bus.dataOK_l2_arb = 1'b0;
    rstn = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    #1;
    checks++; if (grant_idx !== IW'(1) || bus.req_arb_l2 !== 1'b1) begin errs++; $display("FAIL mid_regrant: got idx=%0d req=%b want 1/1", grant_idx, bus.req_arb_l2); end
    c_req = '0;
    drive();
    bus.addrOK_l2_arb = 1'b1;
    bus.dataOK_l2_arb = 1'b1;
    @(negedge clk);
    bus.addrOK_l2_arb = 1'b0;
    bus.dataOK_l2_arb = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp;
    do_reset(3'b011);
    for (int i = 0; i < 6; i++) begin
      exp = pick(3'b011);
      @(negedge clk);
      bus.addrOK_l2_arb = 1'b1;
      #1;
      checks++; if (grant_idx !== IW'(exp) || bus.addrOK_arb_l1 !== N'(1) << exp) begin errs++; $display("FAIL rr_grant%0d: got idx=%0d aok=%b want %0d", i, grant_idx, bus.addrOK_arb_l1, exp); end
      @(negedge clk);
      bus.addrOK_l2_arb = 1'b0;
      bus.dataOK_l2_arb = 1'b1;
      #1;
      checks++; if (bus.dataOK_arb_l1 !== N'(1) << exp) begin errs++; $display("FAIL rr_dataok%0d: got %b want ch%0d", i, bus.dataOK_arb_l1, exp); end
      served(exp);
      @(negedge clk);
      bus.dataOK_l2_arb = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || bus.req_arb_l2 !== 1'b0) begin errs++; $display("FAIL rr_gap%0d: got busy=%b req=%b want 0/0", i, busy, bus.req_arb_l2); end
    end
    c_req = '0;
    drive();
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [LW-1:0] line;
    logic [31:0] ea, ed;
    logic [3:0] es;
    logic ew, same;
    int w, al, dl;
    do_reset('0);
    for (int i = 0; i < 40; i++) begin
      for (int c = 0; c < N; c++) begin
        c_addr[c] = $urandom;
        c_din[c] = $urandom;
        c_wr[c] = 1'($urandom);
        c_wstrb[c] = 4'($urandom);
      end
      r = N'($urandom_range(1, (1 << N) - 1));
      c_req = r;
      drive();
      bus.addrOK_l2_arb = 1'($urandom);
      bus.dataOK_l2_arb = 1'($urandom);
      w = pick(r);
      ea = c_addr[w];
      ed = c_din[w];
      ew = c_wr[w];
      es = c_wstrb[w];
      #1;
      checks++; if (busy !== 1'b0 || bus.addrOK_arb_l1 !== '0 || bus.dataOK_arb_l1 !== '0) begin errs++; $display("FAIL rnd_idle%0d: got busy=%b aok=%b dok=%b want 0", i, busy, bus.addrOK_arb_l1, bus.dataOK_arb_l1); end
      al = $urandom_range(0, 3);
      for (int j = 0; j <= al; j++) begin
        @(negedge clk);
        c_req = N'($urandom);
        c_addr[w] = $urandom;
        drive();
        same = ($urandom_range(0, 3) == 0);
        bus.addrOK_l2_arb = (j == al);
        bus.dataOK_l2_arb = (j == al) ? same : 1'($urandom);
        line = {$urandom, $urandom, $urandom, $urandom};
        bus.dout_l2_arb = line;
        #1;
        checks++; if (bus.req_arb_l2 !== 1'b1 || bus.addr_arb_l2 !== ea || bus.din_arb_l2 !== ed || bus.wr_arb_l2 !== ew || bus.wstrb_arb_l2 !== es || grant_idx !== IW'(w)) begin errs++; $display("FAIL rnd_addr%0d: got %b/%h/%h/%b/%h/%0d want 1/%h/%h/%b/%h/%0d", i, bus.req_arb_l2, bus.addr_arb_l2, bus.din_arb_l2, bus.wr_arb_l2, bus.wstrb_arb_l2, grant_idx, ea, ed, ew, es, w); end
        checks++; if (bus.addrOK_arb_l1 !== ((j == al) ? N'(1) << w : N'(0)) || bus.dataOK_arb_l1 !== ((j == al && same) ? N'(1) << w : N'(0))) begin errs++; $display("FAIL rnd_apulse%0d: got aok=%b dok=%b grant ch%0d", i, bus.addrOK_arb_l1, bus.dataOK_arb_l1, w); end
      end
      if (!same) begin
        dl = $urandom_range(0, 3);
        for (int j = 0; j <= dl; j++) begin
          @(negedge clk);
          bus.addrOK_l2_arb = (j == dl) ? 1'b0 : 1'($urandom);
          bus.dataOK_l2_arb = (j == dl);
          line = {$urandom, $urandom, $urandom, $urandom};
          bus.dout_l2_arb = line;
          #1;
          checks++; if (bus.req_arb_l2 !== 1'b0 || busy !== 1'b1 || bus.addrOK_arb_l1 !== '0) begin errs++; $display("FAIL rnd_data%0d: got req=%b busy=%b aok=%b want 0/1/000", i, bus.req_arb_l2, busy, bus.addrOK_arb_l1); end
          checks++; if (bus.dataOK_arb_l1 !== ((j == dl) ? N'(1) << w : N'(0))) begin errs++; $display("FAIL rnd_dpulse%0d: got %b grant ch%0d", i, bus.dataOK_arb_l1, w); end
        end
      end
      checks++; if (bus.dout_arb_l1 !== line) begin errs++; $display("FAIL rnd_dout%0d: got %h want %h", i, bus.dout_arb_l1, line); end
      served(w);
      @(negedge clk);
      bus.addrOK_l2_arb = 1'b0;
      bus.dataOK_l2_arb = 1'b0;
    end
  endtask

  initial begin
    clear_clients();
    drive();
    bus.addrOK_l2_arb = 1'b0;
    bus.dataOK_l2_arb = 1'b0;
    bus.dout_l2_arb = '0;
    test_reset();
    test_single_read();
    test_same_cycle();
    test_capture();
    test_reset_mid();
    test_round_robin();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
